// File: rtl/gps_pkg.sv
// Shared constants, LFSR feedback masks, PRN phase-select table and FSM encoding
// for the GPS L1 C/A code generator. Bit k-1 of a 10-bit register is ICD stage k.
package gps_pkg;

    localparam int CA_CODE_BITS = 128;
    localparam int CA_EPOCH_LEN = 1023;

    // G1 feedback: stages 3,10.  G2 feedback: stages 2,3,6,8,9,10.
    localparam logic [9:0] G1_FB_MASK = 10'b10_0000_0100;
    localparam logic [9:0] G2_FB_MASK = 10'b11_1010_0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [9:0] tap_pair(input int s1, input int s2);
        return (10'b1 << (s1 - 1)) | (10'b1 << (s2 - 1));
    endfunction

    function automatic logic sv_in_range(input logic [5:0] sv);
        return (sv != 6'd0) && (sv <= 6'd32);
    endfunction

    // G2 phase-select taps per PRN; out-of-range PRNs select nothing.
    function automatic logic [9:0] ca_taps(input logic [5:0] sv);
        logic [9:0] m;
        m = '0;
        case (sv)
            6'd1:  m = tap_pair(2, 6);
            6'd2:  m = tap_pair(3, 7);
            6'd3:  m = tap_pair(4, 8);
            6'd4:  m = tap_pair(5, 9);
            6'd5:  m = tap_pair(1, 9);
            6'd6:  m = tap_pair(2, 10);
            6'd7:  m = tap_pair(1, 8);
            6'd8:  m = tap_pair(2, 9);
            6'd9:  m = tap_pair(3, 10);
            6'd10: m = tap_pair(2, 3);
            6'd11: m = tap_pair(3, 4);
            6'd12: m = tap_pair(5, 6);
            6'd13: m = tap_pair(6, 7);
            6'd14: m = tap_pair(7, 8);
            6'd15: m = tap_pair(8, 9);
            6'd16: m = tap_pair(9, 10);
            6'd17: m = tap_pair(1, 4);
            6'd18: m = tap_pair(2, 5);
            6'd19: m = tap_pair(3, 6);
            6'd20: m = tap_pair(4, 7);
            6'd21: m = tap_pair(5, 8);
            6'd22: m = tap_pair(6, 9);
            6'd23: m = tap_pair(1, 3);
            6'd24: m = tap_pair(4, 6);
            6'd25: m = tap_pair(5, 7);
            6'd26: m = tap_pair(6, 8);
            6'd27: m = tap_pair(7, 9);
            6'd28: m = tap_pair(8, 10);
            6'd29: m = tap_pair(1, 6);
            6'd30: m = tap_pair(2, 7);
            6'd31: m = tap_pair(3, 8);
            6'd32: m = tap_pair(4, 9);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/gps_ca_lfsr.sv
// G1/G2 LFSR pair: chip is combinational from current state, registers advance on step.
// reload (to all-ones) takes priority over step.
module gps_ca_lfsr
    import gps_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       reload,
    input  logic [9:0] taps,
    output logic       chip
);

    logic [9:0] g1;
    logic [9:0] g2;

    assign chip = g1[9] ^ (^(g2 & taps));

    always_ff @(posedge clk) begin
        if (rst) begin
            g1 <= '1;
            g2 <= '1;
        end else if (reload) begin
            g1 <= '1;
            g2 <= '1;
        end else if (step) begin
            g1 <= {g1[8:0], ^(g1 & G1_FB_MASK)};
            g2 <= {g2[8:0], ^(g2 & G2_FB_MASK)};
        end
    end

endmodule

// File: rtl/gps_ca_gen.sv
// C/A code block generator: a rising edge of gen_next produces CODE_BITS chips, one per cycle,
// with code_valid 129 cycles after the sampled edge; edges while running are dropped.
module gps_ca_gen
    import gps_pkg::*;
#(
    parameter int CODE_BITS = CA_CODE_BITS,
    parameter int EPOCH_LEN = CA_EPOCH_LEN
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [5:0]           sv_num,
    input  logic                 gen_next,
    output logic [CODE_BITS-1:0] ca_code,
    output logic                 code_valid,
    output logic                 busy,
    output logic                 epoch,
    output logic [9:0]           chip_idx,
    output logic                 sv_err
);

    localparam int CNT_W = $clog2(CODE_BITS);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(CODE_BITS - 1);
    localparam logic [9:0]       IDX_LAST = 10'(EPOCH_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic             gen_next_q;
    logic             armed;
    logic [5:0]       sv_q;
    logic [CNT_W-1:0] blk_cnt;
    logic             edge_det;
    logic             start;
    logic             finish;
    logic             run;
    logic             wrap;
    logic             sv_change;
    logic             lfsr_chip;
    logic             chip_bit;

    // armed stays low until gen_next has been seen low, so a level held through reset is not a request.
    assign edge_det  = gen_next & ~gen_next_q & armed;
    assign run       = (state == ST_RUN);
    assign wrap      = run && (chip_idx == IDX_LAST);
    assign sv_change = start && (sv_num != sv_q);
    assign chip_bit  = lfsr_chip & ~sv_err;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (edge_det) begin
                    start     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (blk_cnt == BLK_LAST) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gen_next_q <= 1'b0;
            armed      <= 1'b0;
            sv_q       <= '0;
            sv_err     <= 1'b0;
            blk_cnt    <= '0;
            chip_idx   <= '0;
            ca_code    <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            epoch      <= 1'b0;
        end else begin
            gen_next_q <= gen_next;
            armed      <= armed | ~gen_next;
            epoch      <= wrap;
            if (start) begin
                sv_q       <= sv_num;
                sv_err     <= ~sv_in_range(sv_num);
                code_valid <= 1'b0;
                busy       <= 1'b1;
                blk_cnt    <= '0;
                if (sv_change) begin
                    chip_idx <= '0;
                end
            end
            if (run) begin
                ca_code  <= {ca_code[CODE_BITS-2:0], chip_bit};
                blk_cnt  <= blk_cnt + 1'b1;
                chip_idx <= wrap ? 10'd0 : chip_idx + 10'd1;
            end
            if (finish) begin
                code_valid <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

    gps_ca_lfsr u_lfsr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .step   (run),
        .reload (sv_change | wrap),
        .taps   (ca_taps(sv_q)),
        .chip   (lfsr_chip)
    );

endmodule

// File: tb/tb_gps_ca_gen.sv
// Self-checking bench for gps_ca_gen: reference C/A sequences built from the ICD stage
// definitions, expected blocks queued at request time and compared by an independent monitor.
module tb_gps_ca_gen;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic [5:0]   sv_num   = '0;
    logic         gen_next = 1'b0;
    logic [127:0] ca_code;
    logic         code_valid;
    logic         busy;
    logic         epoch;
    logic [9:0]   chip_idx;
    logic         sv_err;

    gps_ca_gen dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .sv_num     (sv_num),
        .gen_next   (gen_next),
        .ca_code    (ca_code),
        .code_valid (code_valid),
        .busy       (busy),
        .epoch      (epoch),
        .chip_idx   (chip_idx),
        .sv_err     (sv_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [127:0] code;
        logic [9:0]   idx;
        logic         err;
        int           epochs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    bit   code_tab [1:32][0:1022];
    int   s1_tab [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int   s2_tab [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    int   model_idx = 0;
    int   model_sv  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic void build_tables();
        for (int p = 1; p <= 32; p++) begin
            int g1 [1:10];
            int g2 [1:10];
            for (int j = 1; j <= 10; j++) begin
                g1[j] = 1;
                g2[j] = 1;
            end
            for (int i = 0; i < 1023; i++) begin
                int f1, f2;
                code_tab[p][i] = bit'(g1[10] ^ g2[s1_tab[p-1]] ^ g2[s2_tab[p-1]]);
                f1 = g1[3] ^ g1[10];
                f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
                for (int j = 10; j >= 2; j--) begin
                    g1[j] = g1[j-1];
                    g2[j] = g2[j-1];
                end
                g1[1] = f1;
                g2[1] = f2;
            end
        end
    endfunction

    function automatic exp_t model_request(input int sv);
        exp_t e;
        bit   ok;
        if (sv != model_sv) begin
            model_idx = 0;
            model_sv  = sv;
        end
        ok       = (sv >= 1) && (sv <= 32);
        e.code   = '0;
        e.err    = ~ok;
        e.epochs = 0;
        for (int k = 0; k < 128; k++) begin
            int c = (model_idx + k) % 1023;
            if (ok) e.code[127-k] = code_tab[sv][c];
            if (c == 1022) e.epochs++;
        end
        model_idx = (model_idx + 128) % 1023;
        e.idx     = 10'(model_idx);
        return e;
    endfunction

    // Monitor: compares each newly completed block against the oldest queued expectation.
    initial begin
        logic cv_prev;
        int   ep_cnt;
        exp_t e;
        cv_prev = 1'b0;
        ep_cnt  = 0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                ep_cnt  = 0;
                cv_prev = 1'b0;
            end else begin
                if (epoch) ep_cnt++;
                if (code_valid && !cv_prev) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL sb_unexpected: got block %h want none", ca_code);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_code", ca_code, e.code);
                        chk("sb_chip_idx", 128'(chip_idx), 128'(e.idx));
                        chk("sb_sv_err", 128'(sv_err), 128'(e.err));
                        chk("sb_epochs", 128'(ep_cnt), 128'(e.epochs));
                    end
                    ep_cnt = 0;
                end
                cv_prev = code_valid;
            end
        end
    end

    task automatic do_reset();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        gen_next = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        model_idx = 0;
        model_sv  = 0;
    endtask

    // Issues one request; abort_at > 0 resets the DUT after that many RUN cycles.
    task automatic request(input int sv, input bit toggles, input bit hold, input int abort_at);
        exp_t e;
        int   n;
        int   busy_cnt;
        bit   done;
        bit   bad;
        e = model_request(sv);
        if (abort_at == 0) sb_q.push_back(e);
        @(posedge wb_clk_i); #1;
        gen_next = 1'b0;
        sv_num   = 6'(sv);
        @(posedge wb_clk_i); #1;
        gen_next = 1'b1;
        @(posedge wb_clk_i);
        n = 0;
        busy_cnt = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge wb_clk_i);
            n++;
            if (busy) busy_cnt++;
            if (n == 1) begin
                chk("start_valid_drop", 128'(code_valid), 128'(0));
                chk("start_busy", 128'(busy), 128'(1));
            end
            if (code_valid) begin
                done = 1'b1;
            end else begin
                @(posedge wb_clk_i); #1;
                if (n == 3) sv_num = 6'($urandom_range(0, 63));
                if (toggles && (n % 9 == 0) && n <= 110) gen_next = ~gen_next;
                if (abort_at != 0 && n == abort_at) begin
                    wb_rst_i = 1'b1;
                    @(posedge wb_clk_i);
                    @(negedge wb_clk_i);
                    chk("abort_valid", 128'(code_valid), 128'(0));
                    chk("abort_busy", 128'(busy), 128'(0));
                    chk("abort_code", ca_code, 128'(0));
                    chk("abort_chip_idx", 128'(chip_idx), 128'(0));
                    @(posedge wb_clk_i); #1;
                    wb_rst_i  = 1'b0;
                    model_idx = 0;
                    model_sv  = 0;
                    bad = 1'b0;
                    repeat (6) begin
                        @(negedge wb_clk_i);
                        if (busy || code_valid) bad = 1'b1;
                    end
                    chk("held_after_reset_no_req", 128'(bad), 128'(0));
                    return;
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL valid_timeout: got no code_valid after %0d cycles want 129", n);
            void'(sb_q.pop_back());
            return;
        end
        chk("latency", 128'(n), 128'(129));
        chk("busy_cycles", 128'(busy_cnt), 128'(128));
        if (hold) begin
            bad = 1'b0;
            repeat (10) begin
                @(negedge wb_clk_i);
                if (busy || !code_valid) bad = 1'b1;
            end
            chk("hold_no_req", 128'(bad), 128'(0));
        end else begin
            @(posedge wb_clk_i); #1;
            gen_next = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int prev_sv;
        logic [127:0] t;
        build_tables();

        do_reset();
        @(negedge wb_clk_i);
        chk("rst_code", ca_code, 128'(0));
        chk("rst_valid", 128'(code_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_epoch", 128'(epoch), 128'(0));
        chk("rst_sv_err", 128'(sv_err), 128'(0));
        chk("rst_chip_idx", 128'(chip_idx), 128'(0));

        request(1, 0, 0, 0);
        t = ca_code;
        chk("prn1_first10", 128'(t[127:118]), 128'(10'b1100100000));
        chk("prn1_chip_idx", 128'(chip_idx), 128'(128));

        do_reset();
        request(2, 0, 0, 0);
        t = ca_code;
        chk("prn2_first10", 128'(t[127:118]), 128'(10'b1110010000));

        do_reset();
        for (int b = 1; b <= 9; b++) begin
            request(1, (b == 2), (b == 3), 0);
            if (b == 8) begin
                t = ca_code;
                chk("wrap_blk8_bit0", 128'(t[0]), 128'(1));
            end
        end
        t = ca_code;
        chk("wrap_blk9_first9", 128'(t[127:119]), 128'(9'b100100000));
        chk("wrap_blk9_chip_idx", 128'(chip_idx), 128'(129));

        request(2, 0, 0, 0);
        t = ca_code;
        chk("svchg_first10", 128'(t[127:118]), 128'(10'b1110010000));
        chk("svchg_chip_idx", 128'(chip_idx), 128'(128));

        request(0, 0, 0, 0);
        chk("sv0_err", 128'(sv_err), 128'(1));
        chk("sv0_code", ca_code, 128'(0));
        chk("sv0_chip_idx", 128'(chip_idx), 128'(128));
        request(40, 1, 0, 0);

        prev_sv = 40;
        for (int r = 0; r < 20; r++) begin
            int sv;
            sv = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : prev_sv;
            request(sv, bit'($urandom_range(0, 1)), 0, 0);
            prev_sv = sv;
        end

        request(7, 0, 0, 50);
        request(1, 0, 0, 0);
        t = ca_code;
        chk("post_abort_first10", 128'(t[127:118]), 128'(10'b1100100000));
        chk("post_abort_chip_idx", 128'(chip_idx), 128'(128));

        repeat (3) @(negedge wb_clk_i);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
